// File: rtl/ula_seq_ctrl.sv
// Sequential 8-bit ALU controller: executes each operation as two 4-bit steps
// on a single shared nibble unit (low nibble first, then high nibble).

module ula_nibble (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);
  always_comb begin
    y    = 4'h0;
    cout = 1'b0;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = a ^ b;
      3'b011: y = ~a;
      3'b100: {cout, y} = {1'b0, a} + {1'b0, b} + {4'h0, cin};
      3'b101: {cout, y} = {1'b0, a} + {1'b0, ~b} + {4'h0, cin};
      3'b110: y = a;
      default: y = 4'h0;
    endcase
  end
endmodule

module ula_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] Op,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Result,
  output logic [3:0] Flags,
  output logic       Err
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_RSV = 3'b111;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       carry_q, carry_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       err_q, err_d;

  logic       sel_hi;
  logic [3:0] nib_a, nib_b, nib_y;
  logic       nib_cin, nib_cout;
  logic       is_arith, b_sign_eff, flag_v, flag_c, flag_z;

  // One nibble unit; operand halves and carry-in are steered by the step.
  assign sel_hi  = (state_q == HIGH);
  assign nib_a   = sel_hi ? a_q[7:4] : a_q[3:0];
  assign nib_b   = sel_hi ? b_q[7:4] : b_q[3:0];
  assign nib_cin = sel_hi ? carry_q : (op_q == OP_SUB);

  ula_nibble u_nibble (
    .op   (op_q),
    .a    (nib_a),
    .b    (nib_b),
    .cin  (nib_cin),
    .y    (nib_y),
    .cout (nib_cout)
  );

  assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign b_sign_eff = (op_q == OP_SUB) ? ~b_q[7] : b_q[7];
  assign flag_v     = is_arith && (a_q[7] == b_sign_eff) && (nib_y[3] != a_q[7]);
  assign flag_c     = is_arith && nib_cout;
  assign flag_z     = ({nib_y, lo_q} == 8'h00);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    lo_d     = lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = Op;
          a_d     = A;
          b_d     = B;
          state_d = LOW;
        end
      end
      LOW: begin
        lo_d    = nib_y;
        carry_d = nib_cout;
        state_d = HIGH;
      end
      HIGH: begin
        result_d = {nib_y, lo_q};
        flags_d  = {nib_y[3], flag_v, flag_c, flag_z};
        err_d    = (op_q == OP_RSV);
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      carry_q  <= 1'b0;
      lo_q     <= 4'h0;
      result_q <= 8'h00;
      flags_q  <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Flags     = flags_q;
  assign Err       = err_q;
endmodule
